axil_selftest_master: RTL

AXIL_SELFTEST_MASTER -- requirements
Module: axil_selftest_master

---
 rtl/axil_selftest_pkg.sv | 34 +++
 rtl/axil_selftest_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/axil_selftest_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_selftest_pkg
// Description : Shared types and constants for the AXI4-Lite self-test master.
//               Holds the controller state enum, the OKAY response code, the
//               register address stride and the index width / address helper.
// Ports       : (package, none)
// Revision    : 1.0 - initial release
// ============================================================================
package axil_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [31:0] ADDR_STRIDE = 32'd4;

  // Wide enough for up to 16 registers plus headroom for the last-index compare.
  localparam int unsigned IDX_W = 5;

  // Byte address of register idx inside the target bank.
  function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                           input logic [IDX_W-1:0] idx);
    return base + ADDR_STRIDE * {27'd0, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_selftest_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_selftest_master
// Description : AXI4-Lite master that, on each rising edge of INIT_AXI_TXN,
//               writes C_M_TRANSACTIONS_NUM registers with start+i, reads them
//               back and compares. One transaction is outstanding at a time.
//               ERROR is sticky for the run; TXN_DONE holds until next start.
// Ports       : M_AXI_ACLK / M_AXI_ARESETN : clock, sync active-low reset
//               INIT_AXI_TXN               : start request (rising edge)
//               TXN_DONE, ERROR            : run status
//               M_AXI_AW*/W*/B*            : write address, data, response
//               M_AXI_AR*/R*               : read address, data
// Revision    : 1.0 - initial release
// ============================================================================
module axil_selftest_master
  import axil_selftest_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0000_0000,
  parameter int unsigned C_M_TRANSACTIONS_NUM       = 4,
  parameter logic [31:0] C_M_START_DATA_VALUE       = 32'h0000_0001
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        INIT_AXI_TXN,
  output logic        TXN_DONE,
  output logic        ERROR,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_M_TRANSACTIONS_NUM - 1);

  state_t           state_q,    state_d;
  logic [IDX_W-1:0] index_q,    index_d;
  logic             init_prev_q;
  logic             awvalid_q,  awvalid_d;
  logic             wvalid_q,   wvalid_d;
  logic             bready_q,   bready_d;
  logic             arvalid_q,  arvalid_d;
  logic             rready_q,   rready_d;
  logic             txn_done_q, txn_done_d;
  logic             error_q,    error_d;

  logic             init_rise;
  logic             is_last;
  logic             aw_done;
  logic             w_done;
  logic [31:0]      exp_data;

  assign init_rise = INIT_AXI_TXN & ~init_prev_q;
  assign is_last   = (index_q == LAST_IDX);
  assign exp_data  = C_M_START_DATA_VALUE + {27'd0, index_q};
  // A channel counts as done once its valid has dropped (handshake in an
  // earlier cycle) or its handshake happens in the current cycle.
  assign aw_done   = ~awvalid_q | M_AXI_AWREADY;
  assign w_done    = ~wvalid_q  | M_AXI_WREADY;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    txn_done_d = txn_done_q;
    error_d    = error_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (init_rise) begin
          state_d    = ST_WR_ADDR;
          index_d    = '0;
          error_d    = 1'b0;
          txn_done_d = 1'b0;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
        end
      end

      ST_WR_ADDR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end

      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) error_d = 1'b1;
          if (is_last) begin
            index_d   = '0;
            state_d   = ST_RD_ADDR;
            arvalid_d = 1'b1;
          end else begin
            index_d   = index_q + IDX_W'(1);
            state_d   = ST_WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end

      ST_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          if ((M_AXI_RDATA != exp_data) || (M_AXI_RRESP != RESP_OKAY)) error_d = 1'b1;
          if (is_last) begin
            state_d    = ST_DONE;
            txn_done_d = 1'b1;
          end else begin
            index_d   = index_q + IDX_W'(1);
            state_d   = ST_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      init_prev_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      txn_done_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      init_prev_q <= INIT_AXI_TXN;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      txn_done_q  <= txn_done_d;
      error_q     <= error_d;
    end
  end

  assign TXN_DONE      = txn_done_q;
  assign ERROR         = error_q;
  assign M_AXI_AWADDR  = reg_addr(C_M_TARGET_SLAVE_BASE_ADDR, index_q);
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = exp_data;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = reg_addr(C_M_TARGET_SLAVE_BASE_ADDR, index_q);
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire
